// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for the pixel-clock domain. Two free-running
//   counters (h_cnt, v_cnt) walk the full raster, including blanking. Every
//   output is a registered decode of the counter value from before the edge,
//   so the outputs trail the counters by exactly one clock.
//
// Ports
//   clk          pixel clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           advance enable; low freezes the raster and mutes the strobes
//   hsync/vsync  sync pulses, asserted level = SYNC_ACTIVE
//   active       visible-region flag for the current output position
//   x, y         current output position (valid during blanking as well)
//   line_start   one-cycle strobe at x == 0
//   frame_start  one-cycle strobe at x == 0, y == 0
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SYNC_ACTIVE = 0,
  parameter int COORD_W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_ACTIVE != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  // Sync level for a counter value against a half-open [lo, hi) window.
  function automatic logic sync_level(input logic [COORD_W-1:0] cnt,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
    return ((cnt >= lo) && (cnt < hi)) ? SYNC_ON : SYNC_OFF;
  endfunction

  function automatic logic is_visible(input logic [COORD_W-1:0] hc,
                                      input logic [COORD_W-1:0] vc);
    return (hc < H_VIS) && (vc < V_VIS);
  endfunction

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;

  // Stage p0: raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Stage p1: registered decode of the pre-increment counters. While stalled
  // the level outputs hold and the strobes drop so none is ever repeated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      x           <= h_cnt;
      y           <= v_cnt;
      active      <= is_visible(h_cnt, v_cnt);
      hsync       <= sync_level(h_cnt, HS_START, HS_END);
      vsync       <= sync_level(v_cnt, VS_START, VS_END);
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: one instance with the default 640x480
// timing and one with a tiny 8x6 raster (active-high syncs) for whole-frame
// and wrap behaviour.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n_d, en_d, rst_n_s, en_s;

  logic       hs_d, vs_d, act_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic       hs_s, vs_s, act_s, ls_s, fs_s;
  logic [3:0] x_s, y_s;

  int total = 0;
  int bad   = 0;

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n_d), .en(en_d),
    .hsync(hs_d), .vsync(vs_d), .active(act_d),
    .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE(1), .COORD_W(4)
  ) dut_s (
    .clk(clk), .rst_n(rst_n_s), .en(en_s),
    .hsync(hs_s), .vsync(vs_s), .active(act_s),
    .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int n_act, n_hs, hs_first, hs_last, n_ls, x_err, y_err, vs_err;
    int e_x, e_y;
    int ex_err, ey_err, ea_err, eh_err, ev_err, el_err, ef_err;
    int n_fs, fs_pos0, fs_pos1, n_hs_s, n_vs_s, n_act_s;
    int frz_err, n_strobe;

    rst_n_d = 1'b0; en_d = 1'b1;
    rst_n_s = 1'b0; en_s = 1'b1;
    adv(3);

    // Reset state, default instance
    chk("rst_hsync", 32'(hs_d), 1);
    chk("rst_vsync", 32'(vs_d), 1);
    chk("rst_active", 32'(act_d), 0);
    chk("rst_x", 32'(x_d), 0);
    chk("rst_y", 32'(y_d), 0);
    chk("rst_ls", 32'(ls_d), 0);
    chk("rst_fs", 32'(fs_d), 0);
    chk("rst_s_hsync", 32'(hs_s), 0);
    chk("rst_s_vsync", 32'(vs_s), 0);

    // First enabled edge after release
    rst_n_d = 1'b1;
    @(negedge clk);
    chk("first_x", 32'(x_d), 0);
    chk("first_y", 32'(y_d), 0);
    chk("first_active", 32'(act_d), 1);
    chk("first_ls", 32'(ls_d), 1);
    chk("first_fs", 32'(fs_d), 1);

    // Line 0 timing
    n_act = 0; n_hs = 0; hs_first = -1; hs_last = -1; n_ls = 0;
    x_err = 0; y_err = 0; vs_err = 0;
    for (int i = 0; i < 800; i++) begin
      if (32'(x_d) != i) x_err++;
      if (y_d != 10'd0) y_err++;
      if (vs_d != 1'b1) vs_err++;
      if (act_d) n_act++;
      if (ls_d) n_ls++;
      if (!hs_d) begin
        n_hs++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      @(negedge clk);
    end
    chk("line_x_seq", 32'(x_err), 0);
    chk("line_y_const", 32'(y_err), 0);
    chk("line_vsync_idle", 32'(vs_err), 0);
    chk("line_active_cnt", 32'(n_act), 640);
    chk("line_hsync_cnt", 32'(n_hs), 96);
    chk("line_hsync_first", 32'(hs_first), 656);
    chk("line_hsync_last", 32'(hs_last), 751);
    chk("line_ls_cnt", 32'(n_ls), 1);
    chk("line1_x", 32'(x_d), 0);
    chk("line1_y", 32'(y_d), 1);
    chk("line1_ls", 32'(ls_d), 1);
    chk("line1_fs", 32'(fs_d), 0);

    // Stall at (799,10)
    adv(7999);
    chk("pre_stall_x", 32'(x_d), 799);
    chk("pre_stall_y", 32'(y_d), 10);
    en_d = 1'b0;
    frz_err = 0; n_strobe = 0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      if (x_d != 10'd799 || y_d != 10'd10 || act_d != 1'b0 || hs_d != 1'b1 || vs_d != 1'b1)
        frz_err++;
      if (ls_d || fs_d) n_strobe++;
    end
    chk("stall_frozen", 32'(frz_err), 0);
    chk("stall_strobes", 32'(n_strobe), 0);
    en_d = 1'b1;
    @(negedge clk);
    chk("resume_x", 32'(x_d), 0);
    chk("resume_y", 32'(y_d), 11);
    chk("resume_ls", 32'(ls_d), 1);
    chk("resume_fs", 32'(fs_d), 0);
    chk("resume_active", 32'(act_d), 1);
    @(negedge clk);
    chk("resume_x1", 32'(x_d), 1);
    chk("resume_ls1", 32'(ls_d), 0);

    // Async reset in the middle of hsync
    adv(699);
    chk("mid_hs_x", 32'(x_d), 700);
    chk("mid_hs_hsync", 32'(hs_d), 0);
    #2 rst_n_d = 1'b0;
    #1;
    chk("arst_x", 32'(x_d), 0);
    chk("arst_y", 32'(y_d), 0);
    chk("arst_hsync", 32'(hs_d), 1);
    chk("arst_active", 32'(act_d), 0);
    @(negedge clk);
    rst_n_d = 1'b1;
    @(negedge clk);
    chk("arst_restart_x", 32'(x_d), 0);
    chk("arst_restart_y", 32'(y_d), 0);
    chk("arst_restart_fs", 32'(fs_d), 1);

    // Small raster: two full frames
    rst_n_s = 1'b1;
    @(negedge clk);
    ex_err = 0; ey_err = 0; ea_err = 0; eh_err = 0; ev_err = 0; el_err = 0; ef_err = 0;
    n_fs = 0; fs_pos0 = -1; fs_pos1 = -1; n_hs_s = 0; n_vs_s = 0; n_act_s = 0;
    for (int n = 0; n < 96; n++) begin
      e_x = n % 8;
      e_y = (n / 8) % 6;
      if (32'(x_s) != e_x) ex_err++;
      if (32'(y_s) != e_y) ey_err++;
      if (act_s != ((e_x < 4) && (e_y < 3))) ea_err++;
      if (hs_s != ((e_x == 5) || (e_x == 6))) eh_err++;
      if (vs_s != (e_y == 4)) ev_err++;
      if (ls_s != (e_x == 0)) el_err++;
      if (fs_s != ((e_x == 0) && (e_y == 0))) ef_err++;
      if (fs_s) begin
        n_fs++;
        if (fs_pos0 < 0) fs_pos0 = n; else fs_pos1 = n;
      end
      if (hs_s) n_hs_s++;
      if (vs_s) n_vs_s++;
      if (act_s) n_act_s++;
      @(negedge clk);
    end
    chk("s_x_seq", 32'(ex_err), 0);
    chk("s_y_seq", 32'(ey_err), 0);
    chk("s_active", 32'(ea_err), 0);
    chk("s_hsync", 32'(eh_err), 0);
    chk("s_vsync", 32'(ev_err), 0);
    chk("s_ls", 32'(el_err), 0);
    chk("s_fs", 32'(ef_err), 0);
    chk("s_fs_cnt", 32'(n_fs), 2);
    chk("s_fs_period", 32'(fs_pos1 - fs_pos0), 48);
    chk("s_hsync_cnt", 32'(n_hs_s), 24);
    chk("s_vsync_cnt", 32'(n_vs_s), 16);
    chk("s_active_cnt", 32'(n_act_s), 24);

    // Small raster: async reset with both syncs asserted
    adv(37);
    chk("s_mid_x", 32'(x_s), 5);
    chk("s_mid_y", 32'(y_s), 4);
    chk("s_mid_hsync", 32'(hs_s), 1);
    chk("s_mid_vsync", 32'(vs_s), 1);
    #2 rst_n_s = 1'b0;
    #1;
    chk("s_arst_x", 32'(x_s), 0);
    chk("s_arst_y", 32'(y_s), 0);
    chk("s_arst_hsync", 32'(hs_s), 0);
    chk("s_arst_vsync", 32'(vs_s), 0);
    chk("s_arst_active", 32'(act_s), 0);
    chk("s_arst_ls", 32'(ls_s), 0);
    @(negedge clk);
    rst_n_s = 1'b1;
    @(negedge clk);
    chk("s_restart_x", 32'(x_s), 0);
    chk("s_restart_y", 32'(y_s), 0);
    chk("s_restart_fs", 32'(fs_s), 1);
    chk("s_restart_active", 32'(act_s), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator clocked by the 25.2 MHz pixel clock (divided PLL output, 24 MHz × 21/5 ÷ 4).
- Produces hsync/vsync, the active-video flag, pixel coordinates, and line/frame strobes for the screensaver renderer and the display pins.
- Default timing is 640×480 @ ~60 Hz: 800 × 525 = 420000 clocks per frame.
- An enable input lets PLL lock (or any qualifier) stall the raster cleanly.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
- COORD_W, 10, width of x/y; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance enable (tie to PLL lock or 1)
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE
- active  out  1  high while the output position is visible
- x  out  COORD_W  horizontal position of current output pixel
- y  out  COORD_W  vertical position of current output pixel
- line_start  out  1  one-cycle strobe when x==0
- frame_start  out  1  one-cycle strobe when x==0 and y==0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK (800); V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK (525).
- Internal counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1).
- On a clk edge with en=1:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When v_cnt is at V_TOTAL-1 at that h wrap, v_cnt wraps to 0.
- All outputs are registered. On each enabled edge, outputs load the decode of the pre-increment counter value (h_cnt, v_cnt), so outputs lag the counter by exactly one cycle.
- Decode rules:
  - x = h_cnt; y = v_cnt. Always valid, including blanking.
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync = SYNC_ACTIVE when H_ACTIVE+H_FRONT ≤ h_cnt < H_ACTIVE+H_FRONT+H_SYNC, else ~SYNC_ACTIVE. Default range is 656..751.
  - vsync = SYNC_ACTIVE when V_ACTIVE+V_FRONT ≤ v_cnt < V_ACTIVE+V_FRONT+V_SYNC, else ~SYNC_ACTIVE. Default lines are 490..491. vsync spans whole lines and changes on the same edge as x returns to 0.
  - line_start = (h_cnt==0); frame_start = (h_cnt==0 && v_cnt==0).
- en=0:
  - Counters hold.
  - x, y, active, hsync, vsync hold their last values.
  - line_start and frame_start are forced to 0. A strobe is never repeated while stalled.
  - When en returns to 1, the sequence continues from the held position. No pixel is skipped or duplicated.
- Reset (rst_n=0, asynchronous, at any time including mid-line or mid-sync):
  - h_cnt=0, v_cnt=0, x=0, y=0, active=0.
  - hsync=~SYNC_ACTIVE, vsync=~SYNC_ACTIVE, line_start=0, frame_start=0.
- First enabled edge after reset release outputs position (0,0): active=1, line_start=1, frame_start=1.
- The wrap of both counters in the same cycle (h=H_TOTAL-1, v=V_TOTAL-1) is the only simultaneous-wrap case. The next output is (0,0) with frame_start=1.
- No combinational path from any input to any output.

Test Plan:
- Reset values: hold rst_n=0 -> hsync=vsync=1, active=0, x=y=0, strobes 0. Release with en=1 -> first edge gives x=0, y=0, active=1, line_start=1, frame_start=1.
- Line timing:
  - Count edges from first output -> active high for 640 edges, low for 160.
  - hsync low exactly for x=656..751 (96 clocks).
  - line_start period is 800 clocks.
- Frame timing: run 2 frames -> frame_start period is 420000 clocks; vsync low only for y=490..491 (1600 clocks); y reaches 524, then x=799,y=524 is followed by x=0,y=0.
- Stall: drop en for 37 cycles at x=799,y=10 -> outputs frozen, no strobes. On re-enable the next output is x=0,y=11 with line_start=1.
- Async reset mid-sync: assert rst_n=0 at x=700,y=491 between clock edges -> outputs go to reset values immediately. After release the sequence restarts at (0,0) with frame_start=1.
- Parameter override H_ACTIVE=4, H_FRONT=1, H_SYNC=2, H_BACK=1, V_ACTIVE=3, V_FRONT=1, V_SYNC=1, V_BACK=1, SYNC_ACTIVE=1 -> line length 8, frame 48 clocks; hsync high only for x=5..6; vsync high only for y=4.
